// File: rtl/multicycle_alu_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : multicycle_alu_if                                                 |
// | Brief   : Request/response handshake bundle for multicycle_alu.             |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
interface multicycle_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] source1;
    logic [WIDTH-1:0] source2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, alu_ctrl, source1, source2, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, overflow
    );

    modport slave (
        input  in_valid, alu_ctrl, source1, source2, out_ready,
        output in_ready, out_valid, result, result_hi, zero, overflow
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : multicycle_alu                                                    |
// | Brief   : WIDTH-bit handshaked ALU with iterative multiplier; optional      |
// |           restoring divider enabled by macro MULTICYCLE_ALU_DIV_EN.         |
// | Revision: 1.0  initial release                                              |
// +-----------------------------------------------------------------------------+
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    multicycle_alu_if.slave bus
);

    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_or  = 4'b0001;
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_sub = 4'b0110;
    localparam logic [3:0] c_op_slt = 4'b0111;
    localparam logic [3:0] c_op_mul = 4'b1000;
    localparam logic [3:0] c_op_sll = 4'b1010;
    localparam logic [3:0] c_op_srl = 4'b1011;
`ifdef MULTICYCLE_ALU_DIV_EN
    localparam logic [3:0] c_op_div = 4'b1001;
`endif

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_zero;
    logic               r_overflow;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_iter;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ovf;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;

    assign w_accept  = bus.in_valid && (r_state == ST_IDLE);
    assign w_is_mul  = (bus.alu_ctrl == c_op_mul);
    assign w_is_iter = w_is_mul || w_is_div;
    assign w_sum     = bus.source1 + bus.source2;
    assign w_diff    = bus.source1 - bus.source2;

`ifdef MULTICYCLE_ALU_DIV_EN
    logic             r_is_div;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH-1:0] w_div_trial;

    assign w_is_div    = (bus.alu_ctrl == c_op_div);
    assign w_div_shift = {r_result_hi, r_result[WIDTH-1]};
    assign w_div_trial = w_div_shift[WIDTH-1:0] - r_opa;
`else
    assign w_is_div = 1'b0;
`endif

    always_comb begin
        w_alu_res = bus.source1 & bus.source2;
        w_alu_ovf = 1'b0;
        case (bus.alu_ctrl)
            c_op_and: w_alu_res = bus.source1 & bus.source2;
            c_op_or:  w_alu_res = bus.source1 | bus.source2;
            c_op_add: begin
                w_alu_res = w_sum;
                w_alu_ovf = (bus.source1[WIDTH-1] == bus.source2[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != bus.source1[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (bus.source1[WIDTH-1] != bus.source2[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != bus.source1[WIDTH-1]);
            end
            c_op_slt: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.source1 < bus.source2)};
            c_op_sll: w_alu_res = bus.source1 << bus.source2[SHW-1:0];
            c_op_srl: w_alu_res = bus.source1 >> bus.source2[SHW-1:0];
            default:  w_alu_res = bus.source1 & bus.source2;
        endcase
    end

    // Multiply: r_result_hi accumulates, r_result holds the multiplier and
    // collects product bits shifted out of the accumulator.
    assign w_mul_sum = {1'b0, r_result_hi} + (r_result[0] ? {1'b0, r_opa} : '0);

    always_comb begin
        w_step_hi = w_mul_sum[WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_result[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
        // Restoring divide: a zero divisor always "fits", which yields an
        // all-ones quotient and leaves the dividend as the remainder.
        if (r_is_div) begin
            if (w_div_shift >= {1'b0, r_opa}) begin
                w_step_hi = w_div_trial;
                w_step_lo = {r_result[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_shift[WIDTH-1:0];
                w_step_lo = {r_result[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (r_count == c_last) w_next_state = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_opa       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
            r_is_div    <= 1'b0;
`endif
        end else if (r_state == ST_IDLE && w_accept) begin
            r_count     <= '0;
            r_result_hi <= '0;
            if (w_is_iter) begin
                r_opa      <= w_is_div ? bus.source2 : bus.source1;
                r_result   <= w_is_div ? bus.source1 : bus.source2;
                r_zero     <= 1'b0;
                r_overflow <= 1'b0;
            end else begin
                r_result   <= w_alu_res;
                r_zero     <= (w_alu_res == '0);
                r_overflow <= w_alu_ovf;
            end
`ifdef MULTICYCLE_ALU_DIV_EN
            r_is_div    <= w_is_div;
`endif
        end else if (r_state == ST_BUSY) begin
            r_count     <= r_count + 1'b1;
            r_result    <= w_step_lo;
            r_result_hi <= w_step_hi;
            r_zero      <= (w_step_lo == '0);
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire
